reg_read_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 4:1 x 46-bit register-select mux among

---
 rtl/reg_read_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_read_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter in front of the shared 4:1 register-select mux.
// Grants one of four requesters, steers the mux, captures the selected word
// one cycle later and presents it on a valid/ready port tagged with its source.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester read request
//   mux_q      combinational mux output (sampled only in SELECT)
//   mux_sel    registered mux select
//   grant      one-hot grant, zero when no transfer is active
//   out_data   captured register word
//   out_src    index of the requester that owns out_data
//   out_valid  out_data/out_src valid
//   out_ready  consumer accept
//   busy       transfer in progress (SELECT or VALID)
module reg_read_arbiter #(
  parameter int unsigned WIDTH = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_q,
  output logic [1:0]       mux_sel,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StSelect, StValid} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       mux_sel_q, mux_sel_d;
  logic [3:0]       grant_q, grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;

  logic [1:0]       arb_base;
  logic [1:0]       cand;
  logic [1:0]       winner;
  logic             any_req;

  assign any_req = |req;

  // During the handshake the source being served becomes the new "last",
  // so arbitrate against it directly instead of waiting for last_q to update.
  assign arb_base = (state_q == StValid) ? out_src_q : last_q;

  // Walk from lowest priority (arb_base itself) to highest (arb_base+1);
  // later hits overwrite earlier ones, so the highest-priority requester wins.
  always_comb begin
    winner = arb_base;
    cand   = arb_base;
    for (int k = 4; k >= 1; k--) begin
      cand = arb_base + 2'(k);
      if (req[cand]) winner = cand;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mux_sel_d   = mux_sel_q;
    grant_d     = grant_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          mux_sel_d = winner;
          grant_d   = 4'b0001 << winner;
          out_src_d = winner;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        // mux_sel has been stable for a full cycle; capture the settled word.
        out_data_d  = mux_q;
        out_valid_d = 1'b1;
        state_d     = StValid;
      end
      StValid: begin
        if (out_valid_q && out_ready) begin
          last_d      = out_src_q;
          out_valid_d = 1'b0;
          if (any_req) begin
            mux_sel_d = winner;
            grant_d   = 4'b0001 << winner;
            out_src_d = winner;
            state_d   = StSelect;
          end else begin
            grant_d = 4'b0000;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= 2'd3;
      mux_sel_q   <= 2'd0;
      grant_q     <= 4'b0000;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mux_sel_q   <= mux_sel_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign grant     = grant_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_reg_read_arbiter.sv
module tb_reg_read_arbiter;

  localparam int unsigned WIDTH = 46;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] mux_q;
  logic [1:0]       mux_sel;
  logic [3:0]       grant;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  logic [WIDTH-1:0] regs [4];

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  reg_read_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_q     (mux_q),
    .mux_sel   (mux_sel),
    .grant     (grant),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Model of the register bank behind the mux.
  assign mux_q = regs[mux_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] src, input logic [WIDTH-1:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: a handshake happens at the next rising edge when these hold mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {18'd0, out_data}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", {18'd0, out_data}, {18'd0, e.data});
        check("sb_src", {62'd0, out_src}, {62'd0, e.src});
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] held;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = 4'b0000;
    out_ready = 1'b0;
    regs[0]   = 46'h1111_2222_3333;
    regs[1]   = 46'h0444_5555_6666;
    regs[2]   = 46'h1234;
    regs[3]   = 46'h2777_8888_9999;

    // 1. Reset state and first grant.
    step();
    step();
    check("rst_mux_sel", {62'd0, mux_sel}, 64'd0);
    check("rst_grant", {60'd0, grant}, 64'd0);
    check("rst_out_data", {18'd0, out_data}, 64'd0);
    check("rst_out_src", {62'd0, out_src}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst       = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    push(2'd0, regs[0]);
    step();
    check("t1_grant", {60'd0, grant}, 64'b0001);
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_valid_early", {63'd0, out_valid}, 64'd0);
    req = 4'b0000;
    step();
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    step();
    check("t1_idle_grant", {60'd0, grant}, 64'd0);
    check("t1_idle_busy", {63'd0, busy}, 64'd0);

    // 2. Single request, two-edge latency.
    req = 4'b0100;
    push(2'd2, 46'h1234);
    step();
    check("t2_mux_sel", {62'd0, mux_sel}, 64'd2);
    check("t2_grant", {60'd0, grant}, 64'b0100);
    check("t2_valid_early", {63'd0, out_valid}, 64'd0);
    req = 4'b0000;
    step();
    check("t2_valid", {63'd0, out_valid}, 64'd1);
    check("t2_data", {18'd0, out_data}, 64'h1234);
    check("t2_src", {62'd0, out_src}, 64'd2);
    step();
    check("t2_idle", {63'd0, busy}, 64'd0);

    // 3. Round robin from reset priority, one word every two cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push(2'(k), regs[k % 4]);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_select_valid", {63'd0, out_valid}, 64'd0);
      check("t3_grant", {60'd0, grant}, 64'(4'b0001 << (k % 4)));
      step();
      check("t3_valid", {63'd0, out_valid}, 64'd1);
      check("t3_src", {62'd0, out_src}, 64'(k % 4));
      if (k == 4) req = 4'b0000;
    end
    step();
    check("t3_idle", {63'd0, busy}, 64'd0);

    // 4. Backpressure while the mux input changes (last=0, so 3 wins).
    out_ready = 1'b0;
    req       = 4'b1000;
    held      = regs[3];
    push(2'd3, held);
    step();
    req = 4'b0000;
    step();
    for (int k = 0; k < 5; k++) begin
      regs[3] = 46'h3ABC_0000_0000 + 46'(k);
      step();
      check("t4_valid", {63'd0, out_valid}, 64'd1);
      check("t4_data", {18'd0, out_data}, {18'd0, held});
      check("t4_src", {62'd0, out_src}, 64'd3);
      check("t4_grant", {60'd0, grant}, 64'b1000);
      check("t4_mux_sel", {62'd0, mux_sel}, 64'd3);
    end
    regs[3]   = held;
    out_ready = 1'b1;
    step();
    check("t4_done_valid", {63'd0, out_valid}, 64'd0);
    check("t4_done_grant", {60'd0, grant}, 64'd0);

    // 5. Request withdrawn after one cycle still completes.
    req = 4'b0010;
    push(2'd1, regs[1]);
    step();
    req = 4'b0000;
    check("t5_grant", {60'd0, grant}, 64'b0010);
    step();
    check("t5_valid", {63'd0, out_valid}, 64'd1);
    check("t5_src", {62'd0, out_src}, 64'd1);
    step();
    check("t5_idle_grant", {60'd0, grant}, 64'd0);
    check("t5_idle_busy", {63'd0, busy}, 64'd0);

    // 6. Reset in VALID drops the transfer and restores priority (last=3).
    out_ready = 1'b0;
    req       = 4'b0100;
    step();
    req = 4'b0000;
    step();
    check("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_grant", {60'd0, grant}, 64'd0);
    out_ready = 1'b1;
    req       = 4'b1001;
    push(2'd0, regs[0]);
    step();
    req = 4'b0000;
    check("t6_prio_grant", {60'd0, grant}, 64'b0001);
    step();
    step();
    req = 4'b1000;
    push(2'd3, regs[3]);
    step();
    req = 4'b0000;
    check("t6_grant3", {60'd0, grant}, 64'b1000);
    step();
    check("t6_src3", {62'd0, out_src}, 64'd3);
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
